fifo_beat_serializer: RTL and testbench
=======================================

Name: fifo_beat_serializer

Overview:
- Reader-side companion to the 362-bit first-word-fall-through (FWFT) sync FIFO.
- Pops one wide entry from the FIFO and streams it downstream as a sequence of narrow beats over a valid/ready handshake, LSB beat first.
- Sits between the FIFO output and narrower consumers such as the debug or trace port and the memory-write path.
- Adds no bubble between packets when the FIFO stays non-empty.

Parameters:
- DATA_W, 362: width of one FIFO entry.
- BEAT_W, 32: width of one output beat.
- NUM_BEATS, 12: beats per entry, equal to ceil(DATA_W/BEAT_W).
- CNT_W, 4: width of the beat counter, equal to clog2(NUM_BEATS).

Ports:
- i_clk, input, 1: clock. All logic is clocked on the rising edge.
- i_rst, input, 1: reset, asynchronous and active-high.
- i_fifo_empty, input, 1: FIFO empty flag. When 0, i_fifo_data holds a valid entry.
- i_fifo_data, input, DATA_W: FWFT head-of-FIFO data.
- o_fifo_r_en, output, 1: pop strobe to the FIFO. Combinational.
- o_valid, output, 1: a beat is presented on o_data.
- i_ready, input, 1: downstream accepts the current beat.
- o_data, output, BEAT_W: current beat.
- o_last, output, 1: current beat is beat NUM_BEATS-1.
- o_beat_idx, output, CNT_W: index of the current beat, 0..NUM_BEATS-1.
- i_flush, input, 1: synchronous abort of the packet in flight.
- o_busy, output, 1: high in state SEND.
- o_pkt_cnt, output, 16: count of completed packets; wraps.

Behaviour:
- Reset (asynchronous, i_rst=1): state=IDLE, shift register=0, beat counter=0, o_pkt_cnt=0. Outputs o_valid=0, o_last=0, o_busy=0, o_data=0, o_fifo_r_en=0.
- State IDLE:
  - o_valid=0.
  - If i_fifo_empty=0 and i_flush=0: o_fifo_r_en=1 in the same cycle, shift register <= i_fifo_data zero-extended to NUM_BEATS*BEAT_W, counter <= 0, next state SEND.
- State SEND:
  - o_valid=1, o_data=shreg[BEAT_W-1:0], o_beat_idx=counter, o_last=(counter==NUM_BEATS-1).
  - Beat accepted when o_valid && i_ready.
  - Accepted and not last: shreg >>= BEAT_W, zero-filled; counter++.
  - Accepted and last: o_pkt_cnt++. Then:
    - if i_fifo_empty=0, pop and load the next entry the same cycle (o_fifo_r_en=1), counter <= 0, stay in SEND;
    - otherwise go to IDLE.
  - Not accepted: o_data, o_last and o_beat_idx hold stable. o_valid never drops without acceptance, except on flush or reset.
- o_fifo_r_en is asserted only in the two load cases above. It is therefore combinationally dependent on i_ready in SEND, and never asserted while i_fifo_empty=1.
- Last-beat packing: beat 11 carries data bits 361:352 in o_data[9:0]; o_data[31:10]=0.
- Latency: entry at the FIFO head in IDLE at cycle T → popped at T, beat 0 valid at T+1. With i_ready held high, a packet occupies exactly 12 cycles, back-to-back packets are contiguous, and the FIFO sees one pop every 12 cycles.
- i_flush (priority over all else except reset):
  - next state IDLE, counter <= 0, o_valid=0 from the next cycle;
  - o_fifo_r_en=0 in the flush cycle;
  - a beat accepted in the flush cycle does not count a packet, even if it is the last beat;
  - the entry in flight is discarded; the FIFO is not re-read.
- Reset asserted mid-packet: immediately return to the reset values; the partial packet is lost.
- o_pkt_cnt wraps 0xFFFF→0x0000.
- o_busy = (state==SEND).

Test Plan:
- Single entry, data = {10'h3A5, 11{32'hC0DE0000 + index i (0..10)}} in the low words, i_ready=1:
  - one pop;
  - beats 0..10 = 32'hC0DE0000..32'hC0DE000A;
  - beat 11 = 32'h000003A5 with o_last=1;
  - o_pkt_cnt=1; IDLE the next cycle.
- Three entries queued, i_ready=1: 36 consecutive valid cycles with no gap; pops at cycles 0, 12 and 24 after start; o_pkt_cnt=3.
- Backpressure: i_ready=0 for 5 cycles on beat 4 → o_data and o_beat_idx=4 held stable for those 5 cycles, no pop; the packet completes in 17 cycles.
- Flush asserted on beat 6 with the FIFO non-empty: no pop in the flush cycle; o_valid=0 the next cycle; o_pkt_cnt unchanged. The next entry starts at beat 0 one cycle later.
- Asynchronous i_rst pulse between clock edges during beat 3: o_valid, o_busy and o_pkt_cnt go to 0 immediately, with no clock edge needed.
- Force o_pkt_cnt to 0xFFFF, complete one packet → o_pkt_cnt=0x0000.

Source files
------------

// File: rtl/fifo_beat_serializer.sv
// Pops one wide FWFT FIFO entry and streams it out as narrow valid/ready beats,
// LSB beat first, reloading on the last beat so packets run back to back.
module fifo_beat_serializer #(
   parameter int DATA_W    = 362,
   parameter int BEAT_W    = 32,
   parameter int NUM_BEATS = 12,
   parameter int CNT_W     = 4
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_fifo_empty,
   input  logic [DATA_W-1:0] i_fifo_data,
   output logic              o_fifo_r_en,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [BEAT_W-1:0] o_data,
   output logic              o_last,
   output logic [CNT_W-1:0]  o_beat_idx,
   input  logic              i_flush,
   output logic              o_busy,
   output logic [15:0]       o_pkt_cnt
);

   localparam int SH_W = NUM_BEATS * BEAT_W;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_BEATS - 1);

   typedef enum logic {
      S_IDLE,
      S_SEND
   } state_t;

   state_t            state;
   state_t            state_n;
   logic [SH_W-1:0]   shreg;
   logic [CNT_W-1:0]  cnt;
   logic [15:0]       pkt_cnt;
   logic              load;
   logic              shift;
   logic              done;
   logic              is_last;

   assign is_last = (cnt == LAST);

   always_comb begin
      state_n = state;
      load    = 1'b0;
      shift   = 1'b0;
      done    = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (!i_flush && !i_fifo_empty) begin
               load    = 1'b1;
               state_n = S_SEND;
            end
         end
         S_SEND: begin
            // flush wins even over an accepted last beat
            if (i_flush) begin
               state_n = S_IDLE;
            end else if (i_ready) begin
               if (is_last) begin
                  done = 1'b1;
                  if (!i_fifo_empty) begin
                     load = 1'b1;
                  end else begin
                     state_n = S_IDLE;
                  end
               end else begin
                  shift = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         shreg   <= '0;
         cnt     <= '0;
         pkt_cnt <= '0;
      end else begin
         if (i_flush) begin
            cnt <= '0;
         end else if (load) begin
            shreg <= SH_W'(i_fifo_data);
            cnt   <= '0;
         end else if (shift) begin
            shreg <= {{BEAT_W{1'b0}}, shreg[SH_W-1:BEAT_W]};
            cnt   <= cnt + CNT_W'(1);
         end
         if (done) begin
            pkt_cnt <= pkt_cnt + 16'd1;
         end
      end
   end

   assign o_fifo_r_en = load;
   assign o_valid     = (state == S_SEND);
   assign o_busy      = (state == S_SEND);
   assign o_data      = shreg[BEAT_W-1:0];
   assign o_beat_idx  = cnt;
   assign o_last      = (state == S_SEND) && is_last;
   assign o_pkt_cnt   = pkt_cnt;

endmodule

// File: tb/tb_fifo_beat_serializer.sv
// Bench for fifo_beat_serializer: queue-based FIFO plus a packet/beat-index
// reference model, directed scenarios followed by randomized traffic.
module tb_fifo_beat_serializer;

   logic          i_clk = 1'b0;
   logic          i_rst;
   logic          i_fifo_empty;
   logic [361:0]  i_fifo_data;
   logic          o_fifo_r_en;
   logic          o_valid;
   logic          i_ready;
   logic [31:0]   o_data;
   logic          o_last;
   logic [3:0]    o_beat_idx;
   logic          i_flush;
   logic          o_busy;
   logic [15:0]   o_pkt_cnt;

   fifo_beat_serializer dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_fifo_empty (i_fifo_empty),
      .i_fifo_data  (i_fifo_data),
      .o_fifo_r_en  (o_fifo_r_en),
      .o_valid      (o_valid),
      .i_ready      (i_ready),
      .o_data       (o_data),
      .o_last       (o_last),
      .o_beat_idx   (o_beat_idx),
      .i_flush      (i_flush),
      .o_busy       (o_busy),
      .o_pkt_cnt    (o_pkt_cnt)
   );

   always #5 i_clk = ~i_clk;

   // reference model: FIFO contents, entry in flight, beat index
   logic [361:0] q[$];
   logic [383:0] cur;
   int           idx;
   bit           busy;
   logic [15:0]  pkts;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int pops = 0;
   int pop_cyc[$];
   bit last_ren;
   bit last_valid;
   logic [3:0] last_idx;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [361:0] rnd_entry();
      logic [383:0] t;
      for (int i = 0; i < 12; i++) t[32*i +: 32] = $urandom;
      return t[361:0];
   endfunction

   task automatic step();
      logic [383:0] sh;
      bit exp_ren;
      i_fifo_empty = (q.size() == 0);
      i_fifo_data  = (q.size() != 0) ? q[0] : '0;
      #1;
      exp_ren = !i_flush && (q.size() != 0) &&
                (!busy || (i_ready && idx == 11));
      chk("valid", 64'(o_valid), 64'(busy));
      chk("busy", 64'(o_busy), 64'(busy));
      chk("r_en", 64'(o_fifo_r_en), 64'(exp_ren));
      chk("pkt_cnt", 64'(o_pkt_cnt), 64'(pkts));
      if (busy) begin
         sh = cur >> (32 * idx);
         chk("data", 64'(o_data), 64'(sh[31:0]));
         chk("beat_idx", 64'(o_beat_idx), 64'(idx));
         chk("last", 64'(o_last), 64'(idx == 11));
      end else begin
         chk("last_idle", 64'(o_last), 64'd0);
      end
      last_ren   = o_fifo_r_en;
      last_valid = o_valid;
      last_idx   = o_beat_idx;
      if (o_fifo_r_en) begin
         pops++;
         pop_cyc.push_back(cyc);
      end
      @(posedge i_clk);
      if (i_flush) begin
         busy = 1'b0;
         idx  = 0;
      end else if (!busy) begin
         if (q.size() != 0) begin
            cur  = 384'(q.pop_front());
            idx  = 0;
            busy = 1'b1;
         end
      end else if (i_ready) begin
         if (idx == 11) begin
            pkts++;
            if (q.size() != 0) begin
               cur = 384'(q.pop_front());
               idx = 0;
            end else begin
               busy = 1'b0;
            end
         end else begin
            idx++;
         end
      end
      @(negedge i_clk);
      cyc++;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((busy || q.size() != 0) && n < 3000) begin
         step();
         n++;
      end
      chk("drain_timeout", 64'(n < 3000), 64'd1);
   endtask

   task automatic step_to_idx(input int target);
      int n;
      n = 0;
      while (!(busy && idx == target) && n < 100) begin
         step();
         n++;
      end
      chk("idx_timeout", 64'(n < 100), 64'd1);
   endtask

   initial begin
      logic [383:0] t;
      int t0;
      i_rst = 1'b1;
      i_ready = 1'b0;
      i_flush = 1'b0;
      i_fifo_empty = 1'b1;
      i_fifo_data = '0;
      busy = 1'b0;
      idx = 0;
      pkts = '0;
      cur = '0;
      repeat (3) @(negedge i_clk);
      chk("rst_valid", 64'(o_valid), 64'd0);
      chk("rst_busy", 64'(o_busy), 64'd0);
      chk("rst_data", 64'(o_data), 64'd0);
      chk("rst_last", 64'(o_last), 64'd0);
      chk("rst_ren", 64'(o_fifo_r_en), 64'd0);
      chk("rst_pkt", 64'(o_pkt_cnt), 64'd0);
      i_rst = 1'b0;
      step();

      // single patterned entry
      t = '0;
      for (int i = 0; i < 11; i++) t[32*i +: 32] = 32'hC0DE0000 + 32'(i);
      t[361:352] = 10'h3A5;
      q.push_back(t[361:0]);
      i_ready = 1'b1;
      pops = 0;
      drain();
      step();
      chk("single_pops", 64'(pops), 64'd1);
      chk("single_pkt", 64'(o_pkt_cnt), 64'd1);
      chk("single_idle", 64'(o_busy), 64'd0);

      // three entries back to back
      for (int i = 0; i < 3; i++) q.push_back(rnd_entry());
      pop_cyc.delete();
      t0 = cyc;
      begin
         int nv;
         nv = 0;
         for (int i = 0; i < 40; i++) begin
            step();
            if (last_valid) nv++;
         end
         chk("b2b_valid_cycles", 64'(nv), 64'd36);
      end
      chk("b2b_npops", 64'(pop_cyc.size()), 64'd3);
      if (pop_cyc.size() == 3) begin
         chk("b2b_pop1", 64'(pop_cyc[1] - pop_cyc[0]), 64'd12);
         chk("b2b_pop2", 64'(pop_cyc[2] - pop_cyc[0]), 64'd24);
      end
      chk("b2b_pkt", 64'(o_pkt_cnt), 64'd4);

      // backpressure on beat 4
      q.push_back(rnd_entry());
      pops = 0;
      step();
      t0 = cyc;
      step_to_idx(4);
      i_ready = 1'b0;
      repeat (5) begin
         step();
         chk("bp_idx_hold", 64'(last_idx), 64'd4);
      end
      i_ready = 1'b1;
      while (busy && cyc - t0 < 100) step();
      chk("bp_cycles", 64'(cyc - t0), 64'd17);
      chk("bp_pops", 64'(pops), 64'd1);

      // flush on beat 6 with the FIFO non-empty
      q.push_back(rnd_entry());
      q.push_back(rnd_entry());
      step();
      step_to_idx(6);
      i_flush = 1'b1;
      step();
      chk("flush_no_pop", 64'(last_ren), 64'd0);
      i_flush = 1'b0;
      step();
      chk("flush_valid_off", 64'(last_valid), 64'd0);
      chk("flush_repop", 64'(last_ren), 64'd1);
      step();
      chk("flush_restart_idx", 64'(last_idx), 64'd0);
      chk("flush_restart_valid", 64'(last_valid), 64'd1);
      drain();
      chk("flush_pkt", 64'(o_pkt_cnt), 64'd6);

      // async reset between edges during beat 3
      q.push_back(rnd_entry());
      step();
      step_to_idx(3);
      #3;
      i_rst = 1'b1;
      #1;
      chk("arst_valid", 64'(o_valid), 64'd0);
      chk("arst_busy", 64'(o_busy), 64'd0);
      chk("arst_pkt", 64'(o_pkt_cnt), 64'd0);
      busy = 1'b0;
      idx = 0;
      pkts = '0;
      @(negedge i_clk);
      i_rst = 1'b0;
      step();

      // packet counter wrap
      force dut.pkt_cnt = 16'hFFFF;
      #1;
      release dut.pkt_cnt;
      pkts = 16'hFFFF;
      q.push_back(rnd_entry());
      drain();
      step();
      chk("wrap_pkt", 64'(o_pkt_cnt), 64'd0);

      // randomized traffic
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 3) == 0 && q.size() < 4) q.push_back(rnd_entry());
         i_ready = ($urandom_range(0, 3) != 0);
         i_flush = ($urandom_range(0, 49) == 0);
         step();
      end
      i_flush = 1'b0;
      i_ready = 1'b1;
      drain();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
